instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0040_0000, PC value loaded at reset.
REQ-002 Parameter TIMEOUT, 8'd255, maximum FETCH wait cycles before fault.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-low; sampled on rising clk edge.
REQ-005 PCWrite  input  1  control unit request to advance the PC; honoured only in VALID.
REQ-006 PCSrc  input  1  PC select: 0 = PC+4, 1 = BranchTarget.
REQ-007 BranchTarget  input  32  jump/branch target address.
REQ-008 MemAddr  output  32  instruction memory address; equals PC.
REQ-009 MemReq  output  1  instruction read request.
REQ-010 MemRdata  input  32  instruction memory read data.
REQ-011 MemReady  input  1  read data valid this cycle.
REQ-012 PC  output  32  address of the current instruction.
REQ-013 PCPlus4  output  32  PC + 4, modulo 2^32.
REQ-014 Instr  output  32  instruction register (IR) contents.
REQ-015 Opcode  output  7  Instr[6:0].
REQ-016 Funct3  output  3  Instr[14:12].
REQ-017 Funct7  output  7  Instr[31:25].
REQ-018 Rd, Rs1, Rs2  output  5 each  Instr[11:7], Instr[19:15], Instr[24:20].
REQ-019 InstrValid  output  1  IR holds a fetched instruction; decoded fields are valid.
REQ-020 Fault  output  2  sticky fault code: 00 none, 01 misaligned target, 10 fetch timeout.

Function
REQ-021 The FSM SHALL have states IDLE, FETCH, VALID and HALT, and no others.
REQ-022 IDLE SHALL go to FETCH unconditionally on the next edge.
REQ-023 In FETCH, MemReq SHALL be 1 and MemAddr SHALL equal PC, held stable until MemReady=1.
- MemReq SHALL be 0 in all other states.
REQ-024 FETCH with MemReady=1: IR <= MemRdata, wait counter <= 0, next state VALID.
- InstrValid SHALL be 1 from the following cycle.
REQ-025 FETCH with MemReady=0: wait counter increments.
- When the counter equals TIMEOUT with MemReady still 0, go to HALT with Fault=10.
- MemReady=1 in the same cycle the counter equals TIMEOUT SHALL take precedence: normal capture, no fault.
REQ-026 VALID SHALL hold IR and PC unchanged while PCWrite=0.
REQ-027 VALID with PCWrite=1 and PCSrc=0: PC <= PC+4 (wraps 32'hFFFF_FFFC -> 0), next state FETCH.
REQ-028 VALID with PCWrite=1 and PCSrc=1:
- BranchTarget[1:0]=00: PC <= BranchTarget, next state FETCH.
- Otherwise: PC unchanged, next state HALT, Fault=01.
REQ-029 InstrValid SHALL be 1 only in VALID; it deasserts the cycle after PCWrite is accepted.
REQ-030 PCWrite SHALL be ignored in IDLE, FETCH and HALT.
REQ-031 HALT SHALL be exited only by reset.
- In HALT: MemReq=0, InstrValid=0; PC and IR keep their last values; Fault is held.
REQ-032 Opcode, Funct3, Funct7, Rd, Rs1, Rs2 and PCPlus4 SHALL be combinational from IR/PC, with no added latency.
REQ-033 MemRdata SHALL be ignored outside FETCH.

Reset
REQ-034 rst=0 at an edge SHALL set: state IDLE, PC=RESET_PC, IR=0, wait counter=0, Fault=00, MemReq=0, InstrValid=0.
REQ-035 Reset SHALL override every other input in any state, including mid-FETCH and HALT; a pending memory response is discarded.

Verification
REQ-036 Reset release, MemReady=1 on first FETCH cycle with MemRdata=32'h00500093 -> MemAddr=32'h0040_0000; then InstrValid=1, Opcode=7'h13, Rd=1, Funct3=0.
REQ-037 VALID, PCWrite=1, PCSrc=0, PC=32'h0040_0000 -> next FETCH MemAddr=32'h0040_0004; InstrValid=0 for that cycle.
REQ-038 VALID, PCWrite=1, PCSrc=1, BranchTarget=32'h0040_0102 -> Fault=01, state HALT, PC stays 32'h0040_0000, MemReq stays 0.
REQ-039 FETCH with MemReady held 0 for 256 cycles -> Fault=10, MemReq=0; with MemReady=1 on cycle 256 instead -> capture, Fault=00.
REQ-040 Assert rst=0 for one edge mid-FETCH with MemReady=1 -> IR=0, PC=RESET_PC, InstrValid=0, then normal fetch resumes.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, requests one instruction at a time
// from instruction memory, latches it in the IR and exposes the decoded fields.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  output logic [31:0] MemAddr,
  output logic        MemReq,
  input  logic [31:0] MemRdata,
  input  logic        MemReady,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] Instr,
  output logic [6:0]  Opcode,
  output logic [2:0]  Funct3,
  output logic [6:0]  Funct7,
  output logic [4:0]  Rd,
  output logic [4:0]  Rs1,
  output logic [4:0]  Rs2,
  output logic        InstrValid,
  output logic [1:0]  Fault
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    HALT
  } state_t;

  localparam logic [1:0] FAULT_NONE      = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN  = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT   = 2'b10;

  state_t      state;
  logic [7:0]  wait_cnt;

  // MemReq and InstrValid are registered alongside the state so they always
  // match the state the FSM is entering; HALT can only be left through reset,
  // which is what makes Fault sticky.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      PC         <= RESET_PC;
      Instr      <= 32'd0;
      wait_cnt   <= 8'd0;
      Fault      <= FAULT_NONE;
      MemReq     <= 1'b0;
      InstrValid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state  <= FETCH;
          MemReq <= 1'b1;
        end
        FETCH: begin
          if (MemReady) begin
            Instr      <= MemRdata;
            wait_cnt   <= 8'd0;
            state      <= VALID;
            MemReq     <= 1'b0;
            InstrValid <= 1'b1;
          end else if (wait_cnt == TIMEOUT) begin
            state  <= HALT;
            Fault  <= FAULT_TIMEOUT;
            MemReq <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        VALID: begin
          if (PCWrite) begin
            InstrValid <= 1'b0;
            if (!PCSrc) begin
              PC     <= PCPlus4;
              state  <= FETCH;
              MemReq <= 1'b1;
            end else if (BranchTarget[1:0] == 2'b00) begin
              PC     <= BranchTarget;
              state  <= FETCH;
              MemReq <= 1'b1;
            end else begin
              state <= HALT;
              Fault <= FAULT_MISALIGN;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
      endcase
    end
  end

  assign MemAddr = PC;
  assign PCPlus4 = PC + 32'd4;

  assign Opcode = Instr[6:0];
  assign Rd     = Instr[11:7];
  assign Funct3 = Instr[14:12];
  assign Rs1    = Instr[19:15];
  assign Rs2    = Instr[24:20];
  assign Funct7 = Instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit against a
// transaction-level model of PC / IR / fault behaviour.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic [31:0] MemAddr;
  logic        MemReq;
  logic [31:0] MemRdata;
  logic        MemReady;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] Instr;
  logic [6:0]  Opcode;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [4:0]  Rd;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;
  logic        InstrValid;
  logic [1:0]  Fault;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [1:0]  m_fault;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(8'd255)) dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .BranchTarget(BranchTarget), .MemAddr(MemAddr), .MemReq(MemReq),
    .MemRdata(MemRdata), .MemReady(MemReady), .PC(PC), .PCPlus4(PCPlus4),
    .Instr(Instr), .Opcode(Opcode), .Funct3(Funct3), .Funct7(Funct7),
    .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .InstrValid(InstrValid), .Fault(Fault)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One-edge reset, then one more edge so the unit is sitting in its first fetch.
  task automatic do_reset;
    rst = 1'b0; PCWrite = 1'b0; MemReady = 1'b0;
    tick;
    m_pc = RESET_PC; m_ir = 32'd0; m_fault = 2'b00;
    tests++;
    if (PC !== m_pc || Fault !== 2'b00 || Instr !== 32'd0) begin
      fails++;
      $display("[TB] FAIL reset_state: pc=%h fault=%b instr=%h, expected %h 00 0", PC, Fault, Instr, m_pc);
    end
    rst = 1'b1;
    tick;
  endtask

  // Memory answers after lat idle cycles; junk inputs must be ignored meanwhile.
  task automatic fetch_one(input int lat, input logic [31:0] data);
    tests++;
    if (MemReq !== 1'b1 || MemAddr !== m_pc) begin
      fails++;
      $display("[TB] FAIL fetch_start: memreq=%b addr=%h, expected 1 %h", MemReq, MemAddr, m_pc);
    end
    for (int i = 0; i < lat; i++) begin
      MemReady = 1'b0; MemRdata = $urandom; PCWrite = 1'($urandom);
      PCSrc = 1'($urandom); BranchTarget = $urandom;
      tick;
      tests++;
      if (MemReq !== 1'b1 || MemAddr !== m_pc || InstrValid !== 1'b0 || Instr !== m_ir || Fault !== 2'b00) begin
        fails++;
        $display("[TB] FAIL fetch_wait: memreq=%b addr=%h valid=%b instr=%h fault=%b, expected 1 %h 0 %h 00",
                 MemReq, MemAddr, InstrValid, Instr, Fault, m_pc, m_ir);
      end
    end
    MemReady = 1'b1; MemRdata = data; PCWrite = 1'($urandom);
    tick;
    MemReady = 1'b0; PCWrite = 1'b0;
    m_ir = data;
    tests++;
    if (InstrValid !== 1'b1 || Instr !== m_ir || MemReq !== 1'b0 || PC !== m_pc ||
        PCPlus4 !== m_pc + 32'd4 || Fault !== 2'b00) begin
      fails++;
      $display("[TB] FAIL fetch_capture: valid=%b instr=%h memreq=%b pc=%h pc4=%h fault=%b, expected 1 %h 0 %h %h 00",
               InstrValid, Instr, MemReq, PC, PCPlus4, Fault, m_ir, m_pc, m_pc + 32'd4);
    end
    tests++;
    if (32'(Opcode) !== (m_ir & 32'h7f) || 32'(Rd) !== ((m_ir >> 7) & 32'h1f) ||
        32'(Funct3) !== ((m_ir >> 12) & 32'h7) || 32'(Rs1) !== ((m_ir >> 15) & 32'h1f) ||
        32'(Rs2) !== ((m_ir >> 20) & 32'h1f) || 32'(Funct7) !== (m_ir >> 25)) begin
      fails++;
      $display("[TB] FAIL decode: op=%h rd=%0d f3=%0d rs1=%0d rs2=%0d f7=%h for instr %h",
               Opcode, Rd, Funct3, Rs1, Rs2, Funct7, m_ir);
    end
  endtask

  task automatic hold_valid(input int n);
    for (int i = 0; i < n; i++) begin
      PCWrite = 1'b0; PCSrc = 1'($urandom); BranchTarget = $urandom;
      MemReady = 1'($urandom); MemRdata = $urandom;
      tick;
      tests++;
      if (PC !== m_pc || Instr !== m_ir || InstrValid !== 1'b1 || MemReq !== 1'b0) begin
        fails++;
        $display("[TB] FAIL valid_hold: pc=%h instr=%h valid=%b memreq=%b, expected %h %h 1 0",
                 PC, Instr, InstrValid, MemReq, m_pc, m_ir);
      end
    end
    MemReady = 1'b0;
  endtask

  task automatic advance(input logic src, input logic [31:0] tgt);
    PCWrite = 1'b1; PCSrc = src; BranchTarget = tgt; MemReady = 1'b0;
    tick;
    PCWrite = 1'b0;
    if (!src) m_pc = m_pc + 32'd4;
    else if (tgt % 4 == 0) m_pc = tgt;
    else m_fault = 2'b01;
    tests++;
    if (InstrValid !== 1'b0 || PC !== m_pc || Fault !== m_fault || MemReq !== (m_fault == 2'b00)) begin
      fails++;
      $display("[TB] FAIL advance: valid=%b pc=%h fault=%b memreq=%b, expected 0 %h %b %b",
               InstrValid, PC, Fault, MemReq, m_pc, m_fault, m_fault == 2'b00);
    end
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      PCWrite = 1'($urandom); PCSrc = 1'($urandom); BranchTarget = $urandom;
      MemReady = 1'($urandom); MemRdata = $urandom;
      tick;
      tests++;
      if (MemReq !== 1'b0 || InstrValid !== 1'b0 || PC !== m_pc || Instr !== m_ir || Fault !== m_fault) begin
        fails++;
        $display("[TB] FAIL halt_hold: memreq=%b valid=%b pc=%h instr=%h fault=%b, expected 0 0 %h %h %b",
                 MemReq, InstrValid, PC, Instr, Fault, m_pc, m_ir, m_fault);
      end
    end
    PCWrite = 1'b0; MemReady = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; PCWrite = 1'b1; PCSrc = 1'b1; MemReady = 1'b1;
    BranchTarget = $urandom; MemRdata = $urandom;
    tick;
    tests++;
    if (PC !== RESET_PC || Instr !== 32'd0 || InstrValid !== 1'b0 || MemReq !== 1'b0 || Fault !== 2'b00) begin
      fails++;
      $display("[TB] FAIL test_reset: pc=%h instr=%h valid=%b memreq=%b fault=%b, expected %h 0 0 0 00",
               PC, Instr, InstrValid, MemReq, Fault, RESET_PC);
    end
    rst = 1'b1; PCWrite = 1'b0; MemReady = 1'b0;
    m_pc = RESET_PC; m_ir = 32'd0; m_fault = 2'b00;
    tick;
  endtask

  task automatic test_first_fetch;
    tests++;
    if (MemAddr !== 32'h0040_0000) begin
      fails++;
      $display("[TB] FAIL first_addr: addr=%h, expected 00400000", MemAddr);
    end
    fetch_one(0, 32'h0050_0093);
    tests++;
    if (InstrValid !== 1'b1 || Opcode !== 7'h13 || Rd !== 5'd1 || Funct3 !== 3'd0) begin
      fails++;
      $display("[TB] FAIL first_decode: valid=%b op=%h rd=%0d f3=%0d, expected 1 13 1 0", InstrValid, Opcode, Rd, Funct3);
    end
  endtask

  task automatic test_sequential;
    advance(1'b0, 32'd0);
    tests++;
    if (MemAddr !== 32'h0040_0004 || InstrValid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL sequential: addr=%h valid=%b, expected 00400004 0", MemAddr, InstrValid);
    end
    fetch_one(2, $urandom);
  endtask

  task automatic test_random_program;
    for (int k = 0; k < 40; k++) begin
      hold_valid($urandom_range(0, 3));
      advance(1'($urandom), $urandom & 32'hFFFF_FFFC);
      fetch_one($urandom_range(0, 6), $urandom);
    end
  endtask

  task automatic test_wrap;
    advance(1'b1, 32'hFFFF_FFFC);
    fetch_one(1, $urandom);
    tests++;
    if (PCPlus4 !== 32'd0) begin
      fails++;
      $display("[TB] FAIL wrap_pcplus4: got %h, expected 00000000", PCPlus4);
    end
    advance(1'b0, 32'd0);
    tests++;
    if (PC !== 32'd0 || MemAddr !== 32'd0) begin
      fails++;
      $display("[TB] FAIL wrap_pc: pc=%h addr=%h, expected 0 0", PC, MemAddr);
    end
    fetch_one(0, $urandom);
  endtask

  task automatic test_misaligned;
    do_reset;
    fetch_one(0, $urandom);
    advance(1'b1, 32'h0040_0102);
    tests++;
    if (Fault !== 2'b01 || PC !== 32'h0040_0000 || MemReq !== 1'b0) begin
      fails++;
      $display("[TB] FAIL misaligned: fault=%b pc=%h memreq=%b, expected 01 00400000 0", Fault, PC, MemReq);
    end
    halt_hold(20);
    do_reset;
    fetch_one(1, $urandom);
    advance(1'b1, ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3)));
    halt_hold(5);
  endtask

  task automatic test_timeout;
    do_reset;
    for (int i = 0; i < 255; i++) begin
      MemReady = 1'b0; MemRdata = $urandom;
      tick;
    end
    tests++;
    if (MemReq !== 1'b1 || Fault !== 2'b00) begin
      fails++;
      $display("[TB] FAIL timeout_early: memreq=%b fault=%b after 255 waits, expected 1 00", MemReq, Fault);
    end
    MemReady = 1'b0;
    tick;
    m_fault = 2'b10;
    tests++;
    if (Fault !== 2'b10 || MemReq !== 1'b0 || InstrValid !== 1'b0 || PC !== RESET_PC) begin
      fails++;
      $display("[TB] FAIL timeout_fault: fault=%b memreq=%b valid=%b pc=%h, expected 10 0 0 %h",
               Fault, MemReq, InstrValid, PC, RESET_PC);
    end
    halt_hold(5);
    do_reset;
    fetch_one(255, $urandom);
    advance(1'b0, 32'd0);
    fetch_one(100, $urandom);
  endtask

  task automatic test_reset_mid_fetch;
    hold_valid(1);
    advance(1'b0, 32'd0);
    rst = 1'b0; MemReady = 1'b1; MemRdata = $urandom;
    tick;
    tests++;
    if (Instr !== 32'd0 || PC !== RESET_PC || InstrValid !== 1'b0 || MemReq !== 1'b0 || Fault !== 2'b00) begin
      fails++;
      $display("[TB] FAIL reset_mid_fetch: instr=%h pc=%h valid=%b memreq=%b fault=%b, expected 0 %h 0 0 00",
               Instr, PC, InstrValid, MemReq, Fault, RESET_PC);
    end
    rst = 1'b1; MemReady = 1'b0;
    m_pc = RESET_PC; m_ir = 32'd0; m_fault = 2'b00;
    tick;
    fetch_one(1, $urandom);
    advance(1'b0, 32'd0);
    fetch_one(0, $urandom);
  endtask

  initial begin
    rst = 1'b0; PCWrite = 1'b0; PCSrc = 1'b0; BranchTarget = 32'd0;
    MemRdata = 32'd0; MemReady = 1'b0;
    m_pc = RESET_PC; m_ir = 32'd0; m_fault = 2'b00;
    test_reset;
    test_first_fetch;
    test_sequential;
    test_random_program;
    test_wrap;
    test_reset_mid_fetch;
    test_misaligned;
    test_timeout;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
